// File: rtl/trace_mon_pkg.sv
// Shared types and helpers for the instruction trace monitor.
package trace_mon_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_HALTED  = 2'd2,
      ST_TIMEOUT = 2'd3
   } state_e;

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// Circular FIFO that overwrites its oldest entry when pushed while full, with a sticky overflow flag.
module trace_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 16
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_flush,
   input  logic                     i_push,
   input  logic [W-1:0]             i_data,
   input  logic                     i_rdy,
   output logic                     o_vld,
   output logic [W-1:0]             o_data,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_ovf
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;
   logic          pop, full;

   assign pop  = i_rdy && (count_q != '0);
   assign full = (count_q == CW'(DEPTH));

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (i_flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         ovf_d    = 1'b0;
      end else begin
         if (i_push) wr_ptr_d = wr_ptr_q + AW'(1);
         // A push into a full buffer advances the read side too, dropping the oldest entry.
         if (pop || (i_push && full)) rd_ptr_d = rd_ptr_q + AW'(1);
         if (i_push && full && !pop) ovf_d = 1'b1;
         if (i_push && !pop && !full) count_d = count_q + CW'(1);
         else if (pop && !i_push)     count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   // NOTE: storage has no reset; emptiness is tracked by count_q and the read data is masked when empty.
   always_ff @(posedge i_clk) begin
      if (i_push && !i_flush) mem_q[wr_ptr_q] <= i_data;
   end

   assign o_vld   = (count_q != '0);
   assign o_data  = o_vld ? mem_q[rd_ptr_q] : '0;
   assign o_count = count_q;
   assign o_ovf   = ovf_q;

endmodule

// File: rtl/insn_trace_monitor.sv
// Run monitor: traces retired PCs, counts retirements, detects halt (PC self-loop) and watchdog timeout.
// Define TRACE_IO_SNAPSHOT_EN to store an IO snapshot alongside each traced PC.
module insn_trace_monitor
   import trace_mon_pkg::*;
#(
   parameter int PC_W     = 32,
   parameter int DEPTH    = 16,
   parameter int HALT_CNT = 4,
`ifdef TRACE_IO_SNAPSHOT_EN
   parameter int IO_W     = 32,
`endif
   parameter int WDOG_W   = 16
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_start,
   input  logic                     i_clear,
   input  logic [PC_W-1:0]          i_pc,
   input  logic                     i_insn_vld,
   input  logic [WDOG_W-1:0]        i_wdog_limit,
`ifdef TRACE_IO_SNAPSHOT_EN
   input  logic [IO_W-1:0]          i_io_ledr,
   output logic [IO_W-1:0]          o_rd_io,
`endif
   output logic                     o_rd_vld,
   input  logic                     i_rd_rdy,
   output logic [PC_W-1:0]          o_rd_pc,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_ovf,
   output logic [31:0]              o_retired,
   output state_e                   o_state,
   output logic                     o_done
);

   localparam int SW = $clog2(HALT_CNT + 1);
`ifdef TRACE_IO_SNAPSHOT_EN
   localparam int EW = IO_W + PC_W;
`else
   localparam int EW = PC_W;
`endif

   state_e            state_q, state_d;
   logic [SW-1:0]     same_q, same_d;
   logic [PC_W-1:0]   last_pc_q, last_pc_d;
   logic [WDOG_W-1:0] wdog_q, wdog_d;
   logic [31:0]       retired_q, retired_d;
   logic              push;
   logic [EW-1:0]     wr_data, rd_data;

   assign push = (state_q == ST_RUN) && i_insn_vld && !i_clear;

   // NOTE: every comb output gets its hold value first so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      same_d    = same_q;
      last_pc_d = last_pc_q;
      wdog_d    = wdog_q;
      retired_d = retired_q;
      if (i_clear) begin
         state_d   = ST_IDLE;
         same_d    = '0;
         last_pc_d = '0;
         wdog_d    = '0;
         retired_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: if (i_start) begin
               state_d   = ST_RUN;
               same_d    = '0;
               wdog_d    = '0;
               retired_d = '0;
            end
            ST_RUN: begin
               wdog_d = wdog_q + WDOG_W'(1);
               if (push) begin
                  retired_d = sat_inc32(retired_q);
                  last_pc_d = i_pc;
                  // same_q == 0 marks the first retirement since start.
                  same_d    = (same_q == '0 || i_pc != last_pc_q) ? SW'(1) : same_q + SW'(1);
               end
               if (push && same_d == SW'(HALT_CNT))
                  state_d = ST_HALTED;
               else if (i_wdog_limit != '0 && wdog_d == i_wdog_limit)
                  state_d = ST_TIMEOUT;
            end
            default: ;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= ST_IDLE;
         same_q    <= '0;
         last_pc_q <= '0;
         wdog_q    <= '0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         same_q    <= same_d;
         last_pc_q <= last_pc_d;
         wdog_q    <= wdog_d;
         retired_q <= retired_d;
      end
   end

`ifdef TRACE_IO_SNAPSHOT_EN
   assign wr_data = {i_io_ledr, i_pc};
   assign o_rd_io = rd_data[EW-1:PC_W];
`else
   assign wr_data = i_pc;
`endif

   trace_fifo #(
      .W     (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_flush (i_clear),
      .i_push  (push),
      .i_data  (wr_data),
      .i_rdy   (i_rd_rdy),
      .o_vld   (o_rd_vld),
      .o_data  (rd_data),
      .o_count (o_count),
      .o_ovf   (o_ovf)
   );

   assign o_rd_pc   = rd_data[PC_W-1:0];
   assign o_retired = retired_q;
   assign o_state   = state_q;
   assign o_done    = (state_q == ST_HALTED) || (state_q == ST_TIMEOUT);

endmodule

// File: tb/tb_insn_trace_monitor.sv
// Directed self-checking bench for insn_trace_monitor (default parameters; IO snapshot test when TRACE_IO_SNAPSHOT_EN).
module tb_insn_trace_monitor;
   import trace_mon_pkg::*;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_start = 1'b0;
   logic        i_clear = 1'b0;
   logic [31:0] i_pc = '0;
   logic        i_insn_vld = 1'b0;
   logic [15:0] i_wdog_limit = '0;
   logic        i_rd_rdy = 1'b0;
   logic        o_rd_vld;
   logic [31:0] o_rd_pc;
   logic [4:0]  o_count;
   logic        o_ovf;
   logic [31:0] o_retired;
   state_e      o_state;
   logic        o_done;
`ifdef TRACE_IO_SNAPSHOT_EN
   logic [31:0] i_io_ledr = '0;
   logic [31:0] o_rd_io;
`endif

   int n_cmp = 0;
   int n_err = 0;

   insn_trace_monitor dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_start      (i_start),
      .i_clear      (i_clear),
      .i_pc         (i_pc),
      .i_insn_vld   (i_insn_vld),
      .i_wdog_limit (i_wdog_limit),
`ifdef TRACE_IO_SNAPSHOT_EN
      .i_io_ledr    (i_io_ledr),
      .o_rd_io      (o_rd_io),
`endif
      .o_rd_vld     (o_rd_vld),
      .i_rd_rdy     (i_rd_rdy),
      .o_rd_pc      (o_rd_pc),
      .o_count      (o_count),
      .o_ovf        (o_ovf),
      .o_retired    (o_retired),
      .o_state      (o_state),
      .o_done       (o_done)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic retire(input logic [31:0] pc);
      i_pc = pc;
      i_insn_vld = 1'b1;
      tick();
      i_insn_vld = 1'b0;
   endtask

   task automatic pulse_start();
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
   endtask

   task automatic pulse_clear();
      i_clear = 1'b1;
      tick();
      i_clear = 1'b0;
   endtask

   task automatic pop_check(input string tag, input logic [31:0] exp);
      check(tag, o_rd_pc, exp);
      i_rd_rdy = 1'b1;
      tick();
      i_rd_rdy = 1'b0;
   endtask

   initial begin
      // Reset values
      #12;
      check("rst_state",   o_state,   ST_IDLE);
      check("rst_count",   o_count,   0);
      check("rst_rd_vld",  o_rd_vld,  0);
      check("rst_rd_pc",   o_rd_pc,   0);
      check("rst_ovf",     o_ovf,     0);
      check("rst_retired", o_retired, 0);
      check("rst_done",    o_done,    0);
      i_rst_n = 1'b1;
      tick();

      // Basic capture and in-order drain
      pulse_start();
      check("t1_state_run", o_state, ST_RUN);
      retire(32'h0);
      retire(32'h4);
      retire(32'h8);
      check("t1_count",   o_count,   3);
      check("t1_retired", o_retired, 3);
      check("t1_rd_vld",  o_rd_vld,  1);
      pop_check("t1_pop0", 32'h0);
      pop_check("t1_pop1", 32'h4);
      pop_check("t1_pop2", 32'h8);
      check("t1_empty_cnt", o_count,  0);
      check("t1_empty_vld", o_rd_vld, 0);

      // Halt detection with a reload on PC change
      pulse_clear();
      pulse_start();
      retire(32'h10);
      retire(32'h14);
      retire(32'h14);
      retire(32'h14);
      retire(32'h18);
      retire(32'h18);
      retire(32'h18);
      check("t2_still_run", o_state, ST_RUN);
      retire(32'h18);
      check("t2_halted",  o_state,   ST_HALTED);
      check("t2_done",    o_done,    1);
      check("t2_retired", o_retired, 8);
      check("t2_count",   o_count,   8);
      retire(32'h50);
      pulse_start();
      check("t2_hold_state",   o_state,   ST_HALTED);
      check("t2_hold_retired", o_retired, 8);
      check("t2_hold_count",   o_count,   8);
      pop_check("t2_pop0", 32'h10);
      check("t2_drain_count", o_count, 7);

      // Watchdog timeout at exactly 20 RUN cycles
      pulse_clear();
      check("t3_clr_state",   o_state,   ST_IDLE);
      check("t3_clr_count",   o_count,   0);
      check("t3_clr_retired", o_retired, 0);
      i_wdog_limit = 16'd20;
      pulse_start();
      for (int i = 0; i < 19; i++) tick();
      check("t3_run_at_19", o_state, ST_RUN);
      tick();
      check("t3_timeout", o_state, ST_TIMEOUT);
      check("t3_done",    o_done,  1);

      // Halt wins over a simultaneous watchdog expiry
      pulse_clear();
      i_wdog_limit = 16'd5;
      pulse_start();
      tick();
      for (int i = 0; i < 4; i++) retire(32'h40);
      check("t3_halt_wins", o_state, ST_HALTED);

      // Watchdog disabled with limit 0
      pulse_clear();
      i_wdog_limit = 16'd0;
      pulse_start();
      for (int i = 0; i < 100; i++) tick();
      check("t3_no_timeout", o_state, ST_RUN);

      // Overwrite on full
      pulse_clear();
      pulse_start();
      for (int i = 0; i < 18; i++) retire(32'(i * 4));
      check("t4_count",   o_count,   16);
      check("t4_ovf",     o_ovf,     1);
      check("t4_retired", o_retired, 18);
      pop_check("t4_pop0", 32'h8);
      check("t4_pop1",  o_rd_pc, 32'hC);
      check("t4_count15", o_count, 15);

      // Empty push+rdy, full push+pop, clear with start
      pulse_clear();
      check("t5_clr_ovf", o_ovf, 0);
      pulse_start();
      i_pc = 32'h300;
      i_insn_vld = 1'b1;
      i_rd_rdy = 1'b1;
      tick();
      i_insn_vld = 1'b0;
      i_rd_rdy = 1'b0;
      check("t5_empty_push_cnt", o_count, 1);
      pop_check("t5_empty_push_pc", 32'h300);
      for (int i = 0; i < 16; i++) retire(32'h100 + 32'(i * 4));
      check("t5_full_cnt", o_count, 16);
      check("t5_full_ovf", o_ovf,   0);
      i_pc = 32'h200;
      i_insn_vld = 1'b1;
      i_rd_rdy = 1'b1;
      tick();
      i_insn_vld = 1'b0;
      i_rd_rdy = 1'b0;
      check("t5_pp_count",   o_count,   16);
      check("t5_pp_ovf",     o_ovf,     0);
      check("t5_pp_head",    o_rd_pc,   32'h104);
      check("t5_pp_retired", o_retired, 18);
      i_clear = 1'b1;
      i_start = 1'b1;
      tick();
      i_clear = 1'b0;
      i_start = 1'b0;
      check("t5_cs_state", o_state,  ST_IDLE);
      check("t5_cs_count", o_count,  0);
      check("t5_cs_vld",   o_rd_vld, 0);

`ifdef TRACE_IO_SNAPSHOT_EN
      // IO snapshot stored with the PC
      pulse_start();
      i_io_ledr = 32'h1F;
      retire(32'h20);
      i_io_ledr = 32'h0;
      check("t6_rd_pc", o_rd_pc, 32'h20);
      check("t6_rd_io", o_rd_io, 32'h1F);
      pulse_clear();
`endif

      // Asynchronous reset mid-run
      pulse_start();
      retire(32'h60);
      retire(32'h64);
      #2;
      i_rst_n = 1'b0;
      #1;
      check("t7_rst_state",   o_state,   ST_IDLE);
      check("t7_rst_count",   o_count,   0);
      check("t7_rst_retired", o_retired, 0);
      check("t7_rst_rd_pc",   o_rd_pc,   0);
      tick();
      i_rst_n = 1'b1;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
